uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares the UART transmit FIFO push port (tfifo_push / tfifo_data_in / tx_full) between NUM_REQ independent 32-bit word sources.
- Sits between the bus-side requesters (AXI4-lite register writer, debug/status sources) and the UART block.
- Grants one requester at a time for a burst of words, which ends on req_last or at MAX_BURST words, so each burst reaches the serial line contiguously.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_BURST, 4, maximum words per grant before forced re-arbitration; legal range 1..16.

Ports:
- clk  input  1  system clock; same clock as the UART push side.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  32*NUM_REQ  per-requester word; requester i uses bits [32*i+31:32*i].
- req_last  input  NUM_REQ  marks final word of requester's burst; sampled only with valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- tfifo_push  output  1  push strobe to UART TX FIFO.
- tfifo_data_in  output  32  word to UART TX FIFO.
- tx_full  input  1  UART TX FIFO full.
- grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE, grant_id=NUM_REQ-1, so the first pick starts at requester 0.
  - burst_cnt=0, busy=0, req_ready=0, tfifo_push=0, tfifo_data_in=0.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching from (grant_id+1) mod NUM_REQ upward with wrap.
  - Register that index into grant_id, go to BUSY, burst_cnt=0.
  - No ready is issued in the cycle the pick is made.
  - Latency from valid to first possible transfer: 1 clock.
- BUSY:
  - req_ready[grant_id] = ~tx_full; all other ready bits are 0.
  - Transfer = req_valid[grant_id] & req_ready[grant_id].
  - tfifo_push = transfer; tfifo_data_in = req_data slice of grant_id.
  - Both are combinational in the transfer cycle; tfifo_data_in holds the last pushed word otherwise.
- BUSY on a transfer:
  - burst_cnt increments.
  - If req_last=1 or burst_cnt==MAX_BURST-1, return to IDLE and clear burst_cnt.
  - grant_id is retained for the next round-robin pointer.
- Grant hold:
  - If the granted requester drops valid without last, the grant is held; no timeout.
  - tx_full=1 stalls the transfer; the grant and burst_cnt are held.
- Simultaneous valids: strict round robin, with the pointer advanced only by a grant.
- MAX_BURST=1: every transfer returns to IDLE, giving word-interleaved round robin.
- Ready → push is same-cycle; data must not change while valid & ~ready.
- rst asserted mid-burst: immediate return to reset values; a word presented in that cycle is not pushed.
- busy = (state==BUSY).
- Valid bits of non-granted requesters are ignored until the next IDLE pick.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has fixed priority in IDLE: if req_valid[0]=1 it is picked regardless of the pointer.
  - Remaining requesters are round-robin among themselves from the pointer.
  - Requester 0 still obeys MAX_BURST and req_last.
- Undefined: pure round robin across all NUM_REQ requesters.

Test Plan:
- Reset, all req_valid=0 → grant_id=3, busy=0, tfifo_push=0 for 10 cycles.
- Req 2 presents one word 0xA5A5_0001 with last=1 → busy rises 1 cycle later; tfifo_push=1 with tfifo_data_in=0xA5A5_0001 on the next cycle; then IDLE, grant_id=2.
- Req 0,1,3 valid simultaneously, one word each with last=1 → push order 0,1,3; one IDLE cycle between words.
- Req 1 streams 6 words without last, MAX_BURST=4, req 2 also valid → 4 words from req 1, then req 2 granted, then the remaining 2 from req 1.
- tx_full held high 5 cycles mid-burst → req_ready=0, no push, grant held; burst resumes on release with no word lost or duplicated.
- With UART_TX_ARB_PRIO0_EN defined, grant_id=0 pointer and req 0,2 always valid → req 0 wins every IDLE pick; without the macro, grants alternate 2,0,2,0.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester/UART-FIFO bundle shared by uart_tx_arb: per-requester word streams and the TX FIFO push port.
// The slave modport is the arbiter; the master modport drives requests and models the FIFO.
interface uart_tx_arb_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned WORD_W = 32;

    logic [NUM_REQ-1:0]        req_valid;
    logic [WORD_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tfifo_push;
    logic [WORD_W-1:0]         tfifo_data_in;
    logic                      tx_full;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tfifo_push, tfifo_data_in
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tfifo_push, tfifo_data_in
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX FIFO push port between NUM_REQ word sources, in bursts.
// Optional macro UART_TX_ARB_PRIO0_EN gives requester 0 fixed priority at each IDLE pick.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arb_if.slave               arb_if,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned GID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  data_q, data_d;

    logic [GID_W-1:0]   pick_idx;
    logic               pick_found;
    logic               gnt_valid;
    logic               gnt_last;
    logic [WORD_W-1:0]  gnt_data;
    logic [NUM_REQ-1:0] ready_c;
    logic               transfer_c;

    // Next requester: first valid bit after the last grant, wrapping
    always_comb begin
        int unsigned      idx;
        logic [GID_W-1:0] idx_g;
        idx        = 0;
        idx_g      = '0;
        pick_idx   = grant_q;
        pick_found = 1'b0;
`ifdef UART_TX_ARB_PRIO0_EN
        if (arb_if.req_valid[0]) begin
            pick_idx   = '0;
            pick_found = 1'b1;
        end
`endif
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx   = (32'(grant_q) + off) % NUM_REQ;
            idx_g = GID_W'(idx);
            if (!pick_found && arb_if.req_valid[idx_g]) begin
                pick_idx   = idx_g;
                pick_found = 1'b1;
            end
        end
    end

    // Mux of the granted requester's stream
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (GID_W'(r) == grant_q) begin
                gnt_valid = arb_if.req_valid[r];
                gnt_last  = arb_if.req_last[r];
                gnt_data  = arb_if.req_data[WORD_W*r +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Ready and push are gated by rst so a word in the reset cycle is never pushed
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ready_c    = '0;
        transfer_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                ready_c[grant_q] = ~arb_if.tx_full & ~rst;
                transfer_c       = gnt_valid & ~arb_if.tx_full & ~rst;
                if (transfer_c) begin
                    data_d = gnt_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (gnt_last || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arb_if.req_ready     = ready_c;
    assign arb_if.tfifo_push    = transfer_c;
    assign arb_if.tfifo_data_in = transfer_c ? gnt_data : data_q;
    assign grant_id             = grant_q;
    assign busy                 = (state_q == BUSY);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized streams vs a burst-level model.
module tb_uart_tx_arb;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned MAXW      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int m_ptr;

    logic [31:0] word_data [NUM_REQ][MAXW];
    bit          word_last [NUM_REQ][MAXW];
    int          word_cnt  [NUM_REQ];

    int          exp_id[$];
    logic [31:0] exp_data[$];
    int          exp_cyc[$];
    bit          model_held;

    uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) arb_if ();

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .arb_if   (arb_if),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_zero();
        arb_if.req_valid = '0;
        arb_if.req_data  = '0;
        arb_if.req_last  = '0;
        arb_if.tx_full   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_zero();
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = NUM_REQ - 1;
    endtask

    task automatic clear_words();
        for (int r = 0; r < NUM_REQ; r++) word_cnt[r] = 0;
    endtask

    // Burst-level model: which requester pushes which word at which cycle (cycle 0 = first IDLE pick)
    task automatic build_model();
        int h [NUM_REQ];
        int t, pick, n, r;
        bit any, lst;
        exp_id.delete();
        exp_data.delete();
        exp_cyc.delete();
        for (int i = 0; i < NUM_REQ; i++) h[i] = 0;
        t = 0;
        model_held = 1'b0;
        forever begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) if (h[i] < word_cnt[i]) any = 1'b1;
            if (!any) break;
            pick = -1;
`ifdef UART_TX_ARB_PRIO0_EN
            if (h[0] < word_cnt[0]) pick = 0;
`endif
            for (int off = 1; off <= NUM_REQ && pick < 0; off++) begin
                r = (m_ptr + off) % NUM_REQ;
                if (h[r] < word_cnt[r]) pick = r;
            end
            m_ptr = pick;
            t++;
            n = 0;
            forever begin
                exp_id.push_back(pick);
                exp_data.push_back(word_data[pick][h[pick]]);
                exp_cyc.push_back(t);
                lst = word_last[pick][h[pick]];
                h[pick]++;
                n++;
                if (lst || n == MAX_BURST) break;
                if (h[pick] == word_cnt[pick]) begin
                    model_held = 1'b1;
                    break;
                end
                t++;
            end
            if (model_held) break;
            t++;
        end
    endtask

    // full_mode: 0 never full (cycle-exact timing checked), 1 random, 2 full during cycles 3..7
    task automatic run_engine(input bit do_reset, input int full_mode);
        int head [NUM_REQ];
        int got, cyc, idx;
        bit full;
        if (do_reset) apply_reset();
        build_model();
        for (int r = 0; r < NUM_REQ; r++) head[r] = 0;
        got = 0;
        cyc = 0;
        while (got < exp_id.size() && cyc < 400) begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                arb_if.req_valid[r]          = (head[r] < word_cnt[r]);
                arb_if.req_data[32*r +: 32]  = (head[r] < word_cnt[r]) ? word_data[r][head[r]] : 32'h0;
                arb_if.req_last[r]           = (head[r] < word_cnt[r]) ? word_last[r][head[r]] : 1'b0;
            end
            case (full_mode)
                1:       full = ($urandom_range(0, 3) == 0);
                2:       full = (cyc >= 3 && cyc <= 7);
                default: full = 1'b0;
            endcase
            arb_if.tx_full = full;
            #1;
            checks++;
            if ($countones(arb_if.req_ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: cycle %0d req_ready=%b, required at most one bit", cyc, arb_if.req_ready);
            end
            if (full) begin
                checks++;
                if (arb_if.req_ready !== '0 || arb_if.tfifo_push !== 1'b0) begin
                    errors++;
                    $display("FAIL full_stall: cycle %0d ready=%b push=%b, required 0/0", cyc, arb_if.req_ready, arb_if.tfifo_push);
                end
                if (full_mode == 2) begin
                    checks++;
                    if (busy !== 1'b1 || grant_id !== 2'(exp_id[got])) begin
                        errors++;
                        $display("FAIL grant_hold: cycle %0d busy=%b grant=%0d, required 1/%0d", cyc, busy, grant_id, exp_id[got]);
                    end
                end
            end
            if (arb_if.tfifo_push === 1'b1) begin
                idx = -1;
                for (int r = 0; r < NUM_REQ; r++) if (arb_if.req_ready[r] === 1'b1) idx = r;
                checks++;
                if (idx != exp_id[got] || arb_if.tfifo_data_in !== exp_data[got]) begin
                    errors++;
                    $display("FAIL push_seq[%0d]: req=%0d data=%h, required req=%0d data=%h",
                             got, idx, arb_if.tfifo_data_in, exp_id[got], exp_data[got]);
                end
                if (full_mode == 0) begin
                    checks++;
                    if (cyc != exp_cyc[got]) begin
                        errors++;
                        $display("FAIL push_time[%0d]: cycle %0d, required %0d", got, cyc, exp_cyc[got]);
                    end
                end
                if (idx >= 0 && head[idx] < word_cnt[idx]) head[idx]++;
                got++;
            end
            cyc++;
        end
        checks++;
        if (got != exp_id.size()) begin
            errors++;
            $display("FAIL push_count: %0d pushes seen, required %0d (cycle budget expired)", got, exp_id.size());
        end
        @(negedge clk);
        drive_zero();
        #1;
        checks++;
        if (busy !== model_held || grant_id !== 2'(m_ptr) || arb_if.tfifo_push !== 1'b0) begin
            errors++;
            $display("FAIL end_state: busy=%b grant=%0d push=%b, required %b/%0d/0", busy, grant_id, arb_if.tfifo_push, model_held, m_ptr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_zero();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = NUM_REQ - 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (grant_id !== 2'd3 || busy !== 1'b0 || arb_if.tfifo_push !== 1'b0 ||
                arb_if.req_ready !== 4'b0 || arb_if.tfifo_data_in !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: cycle %0d grant=%0d busy=%b push=%b ready=%b data=%h, required 3/0/0/0000/0",
                         c, grant_id, busy, arb_if.tfifo_push, arb_if.req_ready, arb_if.tfifo_data_in);
            end
        end
    endtask

    task automatic test_single_word();
        @(negedge clk);
        arb_if.req_valid[2]      = 1'b1;
        arb_if.req_last[2]       = 1'b1;
        arb_if.req_data[64 +: 32] = 32'hA5A5_0001;
        #1;
        checks++;
        if (busy !== 1'b0 || arb_if.tfifo_push !== 1'b0 || arb_if.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL single_pick: busy=%b push=%b ready=%b, required 0/0/0000", busy, arb_if.tfifo_push, arb_if.req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || arb_if.req_ready !== 4'b0100 ||
            arb_if.tfifo_push !== 1'b1 || arb_if.tfifo_data_in !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_push: busy=%b grant=%0d ready=%b push=%b data=%h, required 1/2/0100/1/a5a50001",
                     busy, grant_id, arb_if.req_ready, arb_if.tfifo_push, arb_if.tfifo_data_in);
        end
        @(negedge clk);
        drive_zero();
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd2 || arb_if.tfifo_push !== 1'b0 || arb_if.tfifo_data_in !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_done: busy=%b grant=%0d push=%b data=%h, required 0/2/0/a5a50001",
                     busy, grant_id, arb_if.tfifo_push, arb_if.tfifo_data_in);
        end
        m_ptr = 2;
    endtask

    task automatic test_simultaneous();
        clear_words();
        foreach (word_cnt[r]) begin
            if (r != 2) begin
                word_cnt[r]     = 1;
                word_data[r][0] = 32'h1000_0000 + 32'(r);
                word_last[r][0] = 1'b1;
            end
        end
        run_engine(1'b1, 0);
    endtask

    task automatic test_max_burst();
        clear_words();
        word_cnt[1] = 6;
        for (int i = 0; i < 6; i++) begin
            word_data[1][i] = 32'h0B00_0000 + 32'(i);
            word_last[1][i] = 1'b0;
        end
        word_cnt[2]     = 1;
        word_data[2][0] = 32'h0C00_0000;
        word_last[2][0] = 1'b1;
        run_engine(1'b1, 0);
    endtask

    task automatic test_tx_full();
        clear_words();
        word_cnt[1] = 6;
        for (int i = 0; i < 6; i++) begin
            word_data[1][i] = $urandom;
            word_last[1][i] = (i == 5);
        end
        run_engine(1'b1, 2);
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        @(negedge clk);
        arb_if.req_valid[1]      = 1'b1;
        arb_if.req_data[32 +: 32] = 32'h0000_1111;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (arb_if.tfifo_push !== 1'b1 || arb_if.tfifo_data_in !== 32'h0000_1111) begin
            errors++;
            $display("FAIL midrst_first: push=%b data=%h, required 1/00001111", arb_if.tfifo_push, arb_if.tfifo_data_in);
        end
        @(negedge clk);
        arb_if.req_data[32 +: 32] = 32'h0000_2222;
        rst = 1'b1;
        #1;
        checks++;
        if (arb_if.tfifo_push !== 1'b0 || arb_if.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL midrst_push: push=%b ready=%b, required 0/0000", arb_if.tfifo_push, arb_if.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_zero();
        #1;
        m_ptr = NUM_REQ - 1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd3 || arb_if.tfifo_data_in !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state: busy=%b grant=%0d data=%h, required 0/3/0", busy, grant_id, arb_if.tfifo_data_in);
        end
    endtask

    task automatic test_prio0();
        clear_words();
        word_cnt[0]     = 1;
        word_data[0][0] = 32'h0A00_0000;
        word_last[0][0] = 1'b1;
        run_engine(1'b1, 0);
        clear_words();
        word_cnt[0] = 4;
        word_cnt[2] = 4;
        for (int i = 0; i < 4; i++) begin
            word_data[0][i] = 32'h0A00_0010 + 32'(i);
            word_data[2][i] = 32'h0C00_0010 + 32'(i);
            word_last[0][i] = 1'b1;
            word_last[2][i] = 1'b1;
        end
        run_engine(1'b0, 0);
    endtask

    task automatic test_random();
        int total;
        for (int it = 0; it < 6; it++) begin
            total = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                word_cnt[r] = $urandom_range(0, 6);
                for (int i = 0; i < MAXW; i++) begin
                    word_data[r][i] = $urandom;
                    word_last[r][i] = ($urandom_range(0, 2) == 0) || (i == word_cnt[r] - 1);
                end
                total += word_cnt[r];
            end
            if (total == 0) begin
                word_cnt[0]     = 1;
                word_last[0][0] = 1'b1;
            end
            run_engine(it == 0, (it % 2 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_simultaneous();
        test_max_burst();
        test_tx_full();
        test_reset_mid_burst();
        test_prio0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
